image_rom_arbiter: RTL and testbench
====================================

Name: image_rom_arbiter

Overview:
- Shares the single 100x100-tile image ROM (tile ROM, ImageID*10000 layout) between the display pixel path and one auxiliary requester (cart preview / zoom unit).
- Takes the per-pixel ROM address and image flag from the image locator logic. Issues ROM reads with absolute display priority and returns latency-aligned pixel data to the VGA mux.
- Auxiliary reads use a request/grant handshake. They are served only in cycles the display does not need the ROM, with starvation reporting.

Parameters:
- ADDR_W, 17, ROM address width.
- DATA_W, 24, ROM word width (RGB888).
- ROM_LAT, 2, ROM read latency in cycles from rom_addr to rom_q (1..4).
- STARVE_MAX, 200, aux wait cycles before aux_starved asserts (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- pix_valid  in  1  display active-video pixel this cycle
- disp_isImage  in  1  locator flag: pixel lies on an image tile
- disp_addr  in  ADDR_W  locator ROM address for this pixel
- aux_req  in  1  aux read request; level, held until aux_gnt
- aux_addr  in  ADDR_W  aux read address; stable while aux_req=1
- aux_gnt  out  1  one-cycle pulse: aux request accepted
- aux_rdata_valid  out  1  one-cycle pulse: aux_rdata valid
- aux_rdata  out  DATA_W  aux read data
- aux_starved  out  1  aux waited >= STARVE_MAX cycles
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM data, ROM_LAT cycles after rom_addr
- pix_valid_out  out  1  delayed pix_valid
- pix_isImage_out  out  1  delayed image flag
- pix_rgb_out  out  DATA_W  pixel colour; 0 when not image

Behaviour:
- Reset: all outputs 0, pipelines and tag shift register cleared, FSM to IDLE, starve counter 0. Any in-flight aux read is discarded; no aux_rdata_valid follows. Requester must re-request.
- Display claim at edge k: disp_use = pix_valid & disp_isImage.
  - If disp_use=1: rom_addr <= disp_addr, tag = DISP.
  - Else if aux issue this cycle: rom_addr <= aux_addr, tag = AUX.
  - Else: rom_addr holds, tag = NONE.
- Tag, pix_valid and disp_isImage travel in a ROM_LAT+1 deep shift register alongside the ROM.
- Display output: inputs sampled at edge k appear after edge k+ROM_LAT+1 (3 cycles at default).
  - pix_valid_out and pix_isImage_out are delayed copies of pix_valid and disp_use.
  - pix_rgb_out = rom_q when the delayed tag is DISP, else 0.
  - Fixed latency with no bubbles; display is never stalled.
- Aux FSM:
  - IDLE: aux_req=1 and disp_use=0 -> ISSUE this cycle (aux_gnt=1 at next edge). aux_req=1 and disp_use=1 -> WAIT.
  - WAIT: issue on the first cycle with disp_use=0 -> ISSUE.
  - ISSUE: aux_gnt high for one cycle -> DATA.
  - DATA: when the AUX tag exits the pipeline, aux_rdata <= rom_q and aux_rdata_valid pulses for one cycle -> IDLE.
  - aux_rdata holds its value until the next aux read.
- Aux grant timing: aux_gnt is asserted in the cycle after issue. aux_rdata_valid rises ROM_LAT+1 cycles after the issue edge.
- One outstanding aux read. aux_req is ignored in ISSUE and DATA. The requester drops aux_req on the cycle it sees aux_gnt; if aux_req is still high in IDLE, a new request starts.
- Starvation: an 8-bit counter increments each cycle in WAIT and saturates at 255. aux_starved=1 while counter >= STARVE_MAX. Counter clears on issue; aux_starved drops the same edge. Display priority is not overridden by starvation.
- Simultaneous events:
  - disp_use and aux issue eligibility in the same cycle: display wins.
  - aux_req falling while in WAIT: return to IDLE, counter cleared, no grant.
- Address width: addresses are passed through unmodified; no arithmetic in this block.

Test Plan:
- Display only, ROM_LAT=2, rom_q = address echo. Run a 100-pixel image span at disp_addr 0..99 with pix_valid=1 -> pix_rgb_out 0..99 appears in order, starting 3 cycles after the first sample, no gaps. Non-image pixels give pix_rgb_out=0 and pix_isImage_out=0.
- Aux during blanking (pix_valid=0): aux_req with aux_addr=12345 -> aux_gnt pulse the next cycle, aux_rdata=12345 with aux_rdata_valid 3 cycles after issue. rom_addr=12345 one cycle after issue.
- Collision: aux_req rises mid image span, span ends 40 cycles later -> no grant during the span, grant on the first non-image cycle. Display stream is uncorrupted and aux_starved stays 0.
- Starvation, STARVE_MAX=10: aux_req held through a 100-cycle image run -> aux_starved rises after 10 WAIT cycles. It clears on the grant edge, and the counter reads 0 afterwards.
- Reset mid-operation: assert reset 1 cycle after aux_gnt -> no aux_rdata_valid, all outputs 0 the cycle after reset. A fresh request after reset completes normally.
- Aux withdrawal: aux_req drops while in WAIT -> FSM returns to IDLE, no aux_gnt, aux_starved=0.

Source files
------------

// File: rtl/image_rom_arbiter.sv
// ---------------------------------------------------------------------------
// image_rom_arbiter
//
// Shares the single image tile ROM between the display pixel path and one
// auxiliary requester (cart preview / zoom unit). The display always wins the
// ROM; the aux requester is served only in cycles where the display does not
// need it. Returned display pixels are delay-aligned so the VGA mux sees a
// fixed latency of ROM_LAT+1 cycles from the locator outputs.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   pix_valid         display active-video pixel this cycle
//   disp_isImage      locator flag: pixel lies on an image tile
//   disp_addr         locator ROM address for this pixel
//   aux_req/aux_addr  aux read request (level) and address
//   aux_gnt           one-cycle pulse, aux request accepted
//   aux_rdata_valid   one-cycle pulse, aux_rdata carries the read word
//   aux_rdata         aux read data, held until the next aux read returns
//   aux_starved       aux has waited >= STARVE_MAX cycles for the ROM
//   rom_addr/rom_q    ROM address (registered) and data (ROM_LAT later)
//   pix_valid_out     delayed pix_valid
//   pix_isImage_out   delayed (pix_valid & disp_isImage)
//   pix_rgb_out       pixel colour, 0 when the pixel is not an image pixel
//
// Aux handshake: the requester raises aux_req with aux_addr stable and keeps
// both until it sees the one-cycle aux_gnt pulse, then drops aux_req in that
// same cycle. Exactly one aux read is outstanding at a time; its data comes
// back with a one-cycle aux_rdata_valid pulse. Dropping aux_req before the
// grant withdraws the request without any grant.
// ---------------------------------------------------------------------------
module image_rom_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 24,
    parameter int ROM_LAT    = 2,
    parameter int STARVE_MAX = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              disp_isImage,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rdata_valid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_starved,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic              pix_valid_out,
    output logic              pix_isImage_out,
    output logic [DATA_W-1:0] pix_rgb_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DATA
    } aux_state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_AUX
    } tag_t;

    localparam logic [7:0] STARVE_TH = 8'(STARVE_MAX);

    aux_state_t       state;
    aux_state_t       state_nxt;
    logic [7:0]       starve_cnt;
    logic [7:0]       starve_cnt_nxt;
    logic             disp_use;
    logic             aux_issue;
    logic             aux_ret;
    tag_t             tag_in;

    // Owner tag, pix_valid and display claim ride along with the ROM pipeline.
    // Stage 0 is written on the same edge as rom_addr; stage ROM_LAT lines up
    // with the rom_q word for that address.
    tag_t             tag_sr [0:ROM_LAT];
    logic [ROM_LAT:0] valid_sr;
    logic [ROM_LAT:0] img_sr;

    assign disp_use    = pix_valid & disp_isImage;
    assign aux_gnt     = (state == S_ISSUE);
    assign aux_starved = (starve_cnt >= STARVE_TH);

    // Only our own outstanding read can carry an AUX tag, and the pipeline is
    // flushed on reset, so an AUX tag at the end while in DATA is the return.
    assign aux_ret = (state == S_DATA) && (tag_sr[ROM_LAT] == TAG_AUX);

    // Aux FSM next state, starvation counter and issue decision.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        aux_issue      = 1'b0;
        case (state)
            S_IDLE: begin
                starve_cnt_nxt = 8'd0;
                if (aux_req) begin
                    if (!disp_use) begin
                        aux_issue = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!aux_req) begin
                    state_nxt      = S_IDLE;
                    starve_cnt_nxt = 8'd0;
                end else if (!disp_use) begin
                    aux_issue      = 1'b1;
                    state_nxt      = S_ISSUE;
                    starve_cnt_nxt = 8'd0;
                end else if (starve_cnt != 8'hFF) begin
                    starve_cnt_nxt = starve_cnt + 8'd1;
                end
            end
            S_ISSUE: begin
                starve_cnt_nxt = 8'd0;
                state_nxt      = S_DATA;
            end
            S_DATA: begin
                starve_cnt_nxt = 8'd0;
                if (aux_ret) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                starve_cnt_nxt = 8'd0;
                state_nxt      = S_IDLE;
            end
        endcase
    end

    // Display claim beats any aux issue in the same cycle.
    always_comb begin
        tag_in = TAG_NONE;
        if (disp_use) begin
            tag_in = TAG_DISP;
        end else if (aux_issue) begin
            tag_in = TAG_AUX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            starve_cnt      <= 8'd0;
            rom_addr        <= '0;
            valid_sr        <= '0;
            img_sr          <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_sr[i] <= TAG_NONE;
            end
            pix_valid_out   <= 1'b0;
            pix_isImage_out <= 1'b0;
            pix_rgb_out     <= '0;
            aux_rdata_valid <= 1'b0;
            aux_rdata       <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;

            if (disp_use) begin
                rom_addr <= disp_addr;
            end else if (aux_issue) begin
                rom_addr <= aux_addr;
            end

            tag_sr[0] <= tag_in;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
            valid_sr <= {valid_sr[ROM_LAT-1:0], pix_valid};
            img_sr   <= {img_sr[ROM_LAT-1:0], disp_use};

            pix_valid_out   <= valid_sr[ROM_LAT];
            pix_isImage_out <= img_sr[ROM_LAT];
            pix_rgb_out     <= (tag_sr[ROM_LAT] == TAG_DISP) ? rom_q : '0;

            aux_rdata_valid <= aux_ret;
            if (aux_ret) begin
                aux_rdata <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_image_rom_arbiter
//
// Directed bench for image_rom_arbiter with ROM_LAT=2 and an address-echo
// ROM model. The main instance uses STARVE_MAX=10; a second instance with the
// default STARVE_MAX=200 shares all inputs and its starvation flag must never
// rise in these sequences (longest wait is 99 cycles).
// ---------------------------------------------------------------------------
module tb_image_rom_arbiter;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 24;
    localparam int ROM_LAT = 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              pix_valid;
    logic              disp_isImage;
    logic [ADDR_W-1:0] disp_addr;
    logic              aux_req;
    logic [ADDR_W-1:0] aux_addr;
    logic              aux_gnt;
    logic              aux_rdata_valid;
    logic [DATA_W-1:0] aux_rdata;
    logic              aux_starved;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic              pix_valid_out;
    logic              pix_isImage_out;
    logic [DATA_W-1:0] pix_rgb_out;

    logic              d2_gnt;
    logic              d2_rv;
    logic [DATA_W-1:0] d2_rdata;
    logic              d2_starved;
    logic [ADDR_W-1:0] d2_rom_addr;
    logic              d2_pv;
    logic              d2_pi;
    logic [DATA_W-1:0] d2_rgb;

    image_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .STARVE_MAX(10)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .disp_isImage(disp_isImage),
        .disp_addr(disp_addr), .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
        .aux_rdata_valid(aux_rdata_valid), .aux_rdata(aux_rdata), .aux_starved(aux_starved),
        .rom_addr(rom_addr), .rom_q(rom_q), .pix_valid_out(pix_valid_out),
        .pix_isImage_out(pix_isImage_out), .pix_rgb_out(pix_rgb_out)
    );

    image_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut_dflt (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .disp_isImage(disp_isImage),
        .disp_addr(disp_addr), .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(d2_gnt),
        .aux_rdata_valid(d2_rv), .aux_rdata(d2_rdata), .aux_starved(d2_starved),
        .rom_addr(d2_rom_addr), .rom_q(rom_q), .pix_valid_out(d2_pv),
        .pix_isImage_out(d2_pi), .pix_rgb_out(d2_rgb)
    );

    // Address-echo ROM: rom_q is valid ROM_LAT (=2) cycles after rom_addr.
    logic [ADDR_W-1:0] rom_p1;
    always @(posedge clk) begin
        rom_p1 <= rom_addr;
        rom_q  <= DATA_W'(rom_p1);
    end

    // scoreboard
    int errors = 0;
    int checks = 0;
    logic [25:0] exp_q[$];   // {pix_valid_out, pix_isImage_out, pix_rgb_out}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver: apply one cycle of inputs, advance one edge, check the cycle's
    // display outputs (from the expected queue) and the expected aux pulses.
    task automatic step(input logic pv, input logic img, input int addr,
                        input logic areq, input int aaddr,
                        input logic eg, input logic ev, input logic es);
        logic [25:0] e;
        pix_valid    = pv;
        disp_isImage = img;
        disp_addr    = ADDR_W'(addr);
        aux_req      = areq;
        aux_addr     = ADDR_W'(aaddr);
        exp_q.push_back({pv, pv & img, (pv & img) ? DATA_W'(addr) : 24'd0});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pix_valid_out",   32'(pix_valid_out),   32'(e[25]));
        check("pix_isImage_out", 32'(pix_isImage_out), 32'(e[24]));
        check("pix_rgb_out",     32'(pix_rgb_out),     32'(e[23:0]));
        check("aux_gnt",         32'(aux_gnt),         32'(eg));
        check("aux_rdata_valid", 32'(aux_rdata_valid), 32'(ev));
        check("aux_starved",     32'(aux_starved),     32'(es));
        check("aux_starved_dflt", 32'(d2_starved),     32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pix_valid    = 1'b0;
        disp_isImage = 1'b0;
        disp_addr    = '0;
        aux_req      = 1'b0;
        aux_addr     = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_aux_gnt",     32'(aux_gnt),         32'd0);
            check("rst_rdata_valid", 32'(aux_rdata_valid), 32'd0);
            check("rst_aux_rdata",   32'(aux_rdata),       32'd0);
            check("rst_aux_starved", 32'(aux_starved),     32'd0);
            check("rst_rom_addr",    32'(rom_addr),        32'd0);
            check("rst_pix_valid",   32'(pix_valid_out),   32'd0);
            check("rst_pix_isImage", 32'(pix_isImage_out), 32'd0);
            check("rst_pix_rgb",     32'(pix_rgb_out),     32'd0);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (ROM_LAT + 1) exp_q.push_back(26'd0);
    endtask

    initial begin
        do_reset();

        // Display only: 100-pixel image span, then non-image and blank pixels.
        for (int i = 0; i < 100; i++) step(1, 1, i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)   step(1, 0, 500 + i, 0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)   step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rom_addr_hold", 32'(rom_addr), 32'd99);

        // Aux read during blanking.
        step(0, 0, 0, 1, 12345, 1, 0, 0);
        check("aux_rom_addr", 32'(rom_addr), 32'd12345);
        step(0, 0, 0, 0, 12345, 0, 0, 0);
        step(0, 0, 0, 0, 12345, 0, 0, 0);
        step(0, 0, 0, 0, 12345, 0, 1, 0);
        check("aux_rdata", 32'(aux_rdata), 32'd12345);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("aux_rdata_hold", 32'(aux_rdata), 32'd12345);

        // Collision: aux_req rises mid-span, span ends 40 cycles later.
        for (int i = 0; i < 60; i++)
            step(1, 1, 1000 + i, (i >= 20), 77777, 0, 0, (i >= 30));
        step(1, 0, 1060, 1, 77777, 1, 0, 0);
        check("coll_rom_addr", 32'(rom_addr), 32'd77777);
        step(0, 0, 0, 0, 77777, 0, 0, 0);
        step(0, 0, 0, 0, 77777, 0, 0, 0);
        step(0, 0, 0, 0, 77777, 0, 1, 0);
        check("coll_rdata", 32'(aux_rdata), 32'd77777);

        // Starvation: aux_req held through a 100-cycle image run.
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 2000 + i, 1, 65432, 0, 0, (i >= 10));
            if (i == 50) check("starve_cnt_mid", 32'(dut.starve_cnt), 32'd50);
        end
        step(0, 0, 0, 1, 65432, 1, 0, 0);
        check("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        step(0, 0, 0, 0, 65432, 0, 0, 0);
        step(0, 0, 0, 0, 65432, 0, 0, 0);
        step(0, 0, 0, 0, 65432, 0, 1, 0);
        check("starve_rdata", 32'(aux_rdata), 32'd65432);

        // Reset one cycle after the grant: the read is dropped.
        step(0, 0, 0, 1, 555, 1, 0, 0);
        step(0, 0, 0, 0, 555, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4242, 1, 0, 0);
        step(0, 0, 0, 0, 4242, 0, 0, 0);
        step(0, 0, 0, 0, 4242, 0, 0, 0);
        step(0, 0, 0, 0, 4242, 0, 1, 0);
        check("post_rst_rdata", 32'(aux_rdata), 32'd4242);

        // Withdrawal while waiting behind the display.
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 3000 + i, (i >= 2 && i <= 6), 321, 0, 0, 0);
            if (i == 7) check("wd_starve_cnt", 32'(dut.starve_cnt), 32'd0);
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 321, 0, 0, 0);
        step(0, 0, 0, 1, 321, 1, 0, 0);
        step(0, 0, 0, 0, 321, 0, 0, 0);
        step(0, 0, 0, 0, 321, 0, 0, 0);
        step(0, 0, 0, 0, 321, 0, 1, 0);
        check("wd_rdata", 32'(aux_rdata), 32'd321);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
